// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit (mem_lsu).
// The optional bounds check in mem_lsu is enabled by defining LSU_BOUNDS_CHECK_EN.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsupported funct3 for the direction, or an address not aligned to the access size.
  function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic bad_f3;
    logic misaligned;
    if (we) bad_f3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else    bad_f3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// Combinational data formatting for mem_lsu: load lane extraction/extension and
// sub-word store merging into the previously read memory word.
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_val,
  output logic [31:0] merge_val
);

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {off, 3'b000};
    b = shifted[7:0];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'd0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'd0, h};
      F3_W:    return word;
      default: return 32'd0;
    endcase
  endfunction

  // Word stores pass wdata through, so the same merge also feeds the SW write.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] r;
    r = old;
    case (f3)
      F3_B: begin
        case (off)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      F3_H: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  assign load_val  = load_extract(rd_word, offset, funct3);
  assign merge_val = store_merge(old_word, wdata, offset, funct3);

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator driving a word-wide memory with asynchronous read.
// Sub-word stores are done as read (ACCESS) then merged write (WRITE).
// Optional: define LSU_BOUNDS_CHECK_EN to reject addresses beyond DEPTH_WORDS.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        dm_we,
  output logic [31:0] dm_A,
  output logic [31:0] dm_WD,
  input  logic [31:0] dm_RD
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  lsu_state_t  state_q;
  logic [31:0] addr_q, wdata_q, old_q, rdata_q;
  logic [2:0]  funct3_q;
  logic        we_q, err_q;
  logic        out_of_range, reject;
  logic [31:0] load_val, merge_val;

  assign out_of_range = BOUNDS_EN && ({2'b00, req_addr[31:2]} >= $unsigned(DEPTH_WORDS));
  assign reject       = req_illegal(req_we, req_funct3, req_addr[1:0]) || out_of_range;

  lsu_fmt u_fmt (
    .rd_word  (dm_RD),
    .old_word (old_q),
    .wdata    (wdata_q),
    .offset   (addr_q[1:0]),
    .funct3   (funct3_q),
    .load_val (load_val),
    .merge_val(merge_val)
  );

  assign req_ready  = (state_q == IDLE);
  assign stall      = ~req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dm_A       = {addr_q[31:2], 2'b00};
  // Writes only in ACCESS for SW or in WRITE for the merged SB/SH word.
  assign dm_we      = ((state_q == ACCESS) && we_q && (funct3_q == F3_W)) || (state_q == WRITE);
  assign dm_WD      = dm_we ? merge_val : 32'd0;

  // Request capture, FSM sequencing and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      old_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wdata_q  <= req_wdata;
            if (reject) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_val;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (funct3_q == F3_W) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else begin
            old_q   <= dm_RD;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
